// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states,
// forwarding-select and result-source encodings, and a dependency helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_LINK = 2'b10
    } mtr_t;

    // A source depends on a producer only if the producer really writes a
    // register other than $0.
    function automatic logic dep(input logic [4:0] src, input logic [4:0] dst,
                                 input logic we);
        return we && (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding selects for the E-stage ALU operands and the
// D-stage branch comparator. Disabled (all register-file) while halted.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       en,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] writereg_m,
    input  logic [4:0] writereg_w,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    input  logic [1:0] memtoreg_m,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       fwd_a_d,
    output logic       fwd_b_d
);

    // M wins over W: it holds the younger, more recent value.
    function automatic fwd_t sel_e(input logic [4:0] src);
        if (dep(src, writereg_m, regwrite_m))      return FWD_MEM;
        else if (dep(src, writereg_w, regwrite_w)) return FWD_WB;
        else                                       return FWD_RF;
    endfunction

    logic m_is_alu;
    assign m_is_alu = (memtoreg_m == MTR_ALU);

    assign fwd_a_e = en ? sel_e(rs_e) : FWD_RF;
    assign fwd_b_e = en ? sel_e(rt_e) : FWD_RF;
    assign fwd_a_d = en && m_is_alu && dep(rs_d, writereg_m, regwrite_m);
    assign fwd_b_d = en && m_is_alu && dep(rt_d, writereg_m, regwrite_m);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: stall and flush
// generation, HALT drain FSM and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       writereg_e,
    input  logic [4:0]       writereg_m,
    input  logic [4:0]       writereg_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic [1:0]       memtoreg_e,
    input  logic [1:0]       memtoreg_m,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic             jumpr_d,
    input  logic             pcsrc_d,
    input  logic             load_d,
    input  logic             resume,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t         state, state_nx;
    logic [DW-1:0]  drain_cnt, drain_nx;
    logic           resume_flush, resume_flush_nx;

    fwd_unit u_fwd (
        .en         (state != HALTED),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .rs_e       (rs_e),
        .rt_e       (rt_e),
        .writereg_m (writereg_m),
        .writereg_w (writereg_w),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .memtoreg_m (memtoreg_m),
        .fwd_a_e    (fwd_a_e),
        .fwd_b_e    (fwd_b_e),
        .fwd_a_d    (fwd_a_d),
        .fwd_b_d    (fwd_b_d)
    );

    logic lwstall, brstall, hz_stall;
    logic m_not_alu;
    assign m_not_alu = (memtoreg_m != MTR_ALU);

    assign lwstall = (memtoreg_e == MTR_MEM) &&
                     (dep(rs_d, writereg_e, regwrite_e) || dep(rt_d, writereg_e, regwrite_e));

    // A comparator in D can take an M ALU result, but nothing still in E and
    // no non-ALU result in M.
    assign brstall =
        (branch_d && (dep(rs_d, writereg_e, regwrite_e) || dep(rt_d, writereg_e, regwrite_e) ||
                      (m_not_alu && (dep(rs_d, writereg_m, regwrite_m) ||
                                     dep(rt_d, writereg_m, regwrite_m))))) ||
        (jumpr_d  && (dep(rs_d, writereg_e, regwrite_e) ||
                      (m_not_alu && dep(rs_d, writereg_m, regwrite_m))));

    assign hz_stall = lwstall || brstall;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nx        = state;
        drain_nx        = drain_cnt;
        resume_flush_nx = 1'b0;
        stall_f         = hz_stall;
        stall_d         = hz_stall;
        flush_e         = hz_stall;
        flush_d         = resume_flush || ((pcsrc_d || jump_d || jumpr_d) && !hz_stall);
        halted          = 1'b0;
        case (state)
            RUN: begin
                // The cycle after resume still has the old HALT in IF/ID being
                // flushed; it must not be accepted a second time.
                if (!load_d && !hz_stall && !resume_flush) begin
                    state_nx = DRAIN;
                    drain_nx = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                flush_d = 1'b0;
                if (drain_cnt == '0) state_nx = HALTED;
                else                 drain_nx = drain_cnt - 1'b1;
            end
            HALTED: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                flush_d = 1'b0;
                halted  = 1'b1;
                if (resume) begin
                    state_nx        = RUN;
                    resume_flush_nx = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            drain_cnt    <= '0;
            resume_flush <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_nx;
            drain_cnt    <= drain_nx;
            resume_flush <= resume_flush_nx;
            if (state == RUN && hz_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (counter narrowed to 4 bits
// so saturation is reachable quickly).
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic regwrite_e, regwrite_m, regwrite_w;
    logic [1:0] memtoreg_e, memtoreg_m;
    logic branch_d, jump_d, jumpr_d, pcsrc_d, load_d, resume;
    logic stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, halted;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .jump_d(jump_d), .jumpr_d(jumpr_d), .pcsrc_d(pcsrc_d),
        .load_d(load_d), .resume(resume),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    // {stall_f, stall_d, flush_e, flush_d}
    logic [3:0] sf;
    assign sf = {stall_f, stall_d, flush_e, flush_d};

    task automatic idle();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        writereg_e = 0; writereg_m = 0; writereg_w = 0;
        regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
        memtoreg_e = 0; memtoreg_m = 0;
        branch_d = 0; jump_d = 0; jumpr_d = 0; pcsrc_d = 0;
        load_d = 1; resume = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lw_hazard();
        memtoreg_e = 2'b01; regwrite_e = 1; writereg_e = 8; rs_d = 8;
    endtask

    task automatic test_reset();
        idle();
        load_d = 0;
        rst_n  = 0;
        #3;
        n_vec++;
        if ({sf, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, halted, stall_cycles} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got sf=%b fa=%b fb=%b fd=%b%b h=%b cnt=%0d expected all 0",
                     sf, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, halted, stall_cycles);
        end
        load_d = 1;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load_use();
        idle(); step();
        lw_hazard();
        #1;
        n_vec++;
        if (sf !== 4'b1110) begin n_err++; $display("FAIL lw_stall: got %b expected 1110", sf); end
        step();
        idle();
        rs_e = 8; writereg_m = 8; regwrite_m = 1; memtoreg_m = 2'b01;
        #1;
        n_vec++;
        if (sf !== 4'b0000) begin n_err++; $display("FAIL lw_after: got %b expected 0000", sf); end
        n_vec++;
        if (fwd_a_e !== 2'b10) begin n_err++; $display("FAIL lw_fwd_m: got %b expected 10", fwd_a_e); end
        n_vec++;
        if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL lw_count: got %0d expected 1", stall_cycles); end
    endtask

    task automatic test_double_forward();
        idle(); step();
        writereg_m = 5; writereg_w = 5; regwrite_m = 1; regwrite_w = 1; rs_e = 5; rt_e = 5;
        #1;
        n_vec++;
        if ({fwd_a_e, fwd_b_e} !== 4'b1010) begin n_err++; $display("FAIL dbl_fwd: got %b expected 1010", {fwd_a_e, fwd_b_e}); end
        rs_e = 0;
        #1;
        n_vec++;
        if ({fwd_a_e, fwd_b_e} !== 4'b0010) begin n_err++; $display("FAIL dbl_fwd_r0: got %b expected 0010", {fwd_a_e, fwd_b_e}); end
        rs_e = 5; regwrite_m = 0;
        #1;
        n_vec++;
        if ({fwd_a_e, fwd_b_e} !== 4'b0101) begin n_err++; $display("FAIL fwd_wb: got %b expected 0101", {fwd_a_e, fwd_b_e}); end
    endtask

    task automatic test_branch_m();
        idle(); step();
        branch_d = 1; memtoreg_m = 2'b01; regwrite_m = 1; writereg_m = 9; rt_d = 9;
        #1;
        n_vec++;
        if ({sf, fwd_b_d} !== 5'b11100) begin n_err++; $display("FAIL br_m_load: got %b expected 11100", {sf, fwd_b_d}); end
        memtoreg_m = 2'b00;
        #1;
        n_vec++;
        if ({sf, fwd_b_d} !== 5'b00001) begin n_err++; $display("FAIL br_m_alu: got %b expected 00001", {sf, fwd_b_d}); end
    endtask

    task automatic test_taken_branch();
        idle(); step();
        branch_d = 1; pcsrc_d = 1;
        #1;
        n_vec++;
        if (sf !== 4'b0001) begin n_err++; $display("FAIL taken: got %b expected 0001", sf); end
        writereg_e = 3; regwrite_e = 1; rs_d = 3;
        #1;
        n_vec++;
        if (sf !== 4'b1110) begin n_err++; $display("FAIL taken_brstall: got %b expected 1110", sf); end
        step();
        writereg_e = 0; regwrite_e = 0; writereg_m = 3; regwrite_m = 1;
        #1;
        n_vec++;
        if ({sf, fwd_a_d} !== 5'b00011) begin n_err++; $display("FAIL br_alu_resolved: got %b expected 00011", {sf, fwd_a_d}); end
        n_vec++;
        if (stall_cycles !== 4'd2) begin n_err++; $display("FAIL br_count: got %0d expected 2", stall_cycles); end
        idle();
        jumpr_d = 1; rt_d = 4; writereg_e = 4; regwrite_e = 1;
        #1;
        n_vec++;
        if (sf !== 4'b0001) begin n_err++; $display("FAIL jr_rt_ignored: got %b expected 0001", sf); end
        rs_d = 4;
        #1;
        n_vec++;
        if (sf !== 4'b1110) begin n_err++; $display("FAIL jr_stall: got %b expected 1110", sf); end
    endtask

    task automatic test_branch_e_load();
        idle(); step();
        branch_d = 1; rs_d = 7; writereg_e = 7; regwrite_e = 1; memtoreg_e = 2'b01;
        #1;
        n_vec++;
        if (sf !== 4'b1110) begin n_err++; $display("FAIL brld_c1: got %b expected 1110", sf); end
        step();
        writereg_e = 0; regwrite_e = 0; memtoreg_e = 0;
        writereg_m = 7; regwrite_m = 1; memtoreg_m = 2'b01;
        #1;
        n_vec++;
        if ({sf, fwd_a_d} !== 5'b11100) begin n_err++; $display("FAIL brld_c2: got %b expected 11100", {sf, fwd_a_d}); end
        step();
        writereg_m = 0; regwrite_m = 0; memtoreg_m = 0; writereg_w = 7; regwrite_w = 1;
        #1;
        n_vec++;
        if (sf !== 4'b0000) begin n_err++; $display("FAIL brld_c3: got %b expected 0000", sf); end
        n_vec++;
        if (stall_cycles !== 4'd4) begin n_err++; $display("FAIL brld_count: got %0d expected 4", stall_cycles); end
    endtask

    task automatic test_halt();
        idle(); step();
        load_d = 0; lw_hazard();
        step();
        idle();
        #1;
        n_vec++;
        if ({sf, halted} !== 5'b00000) begin n_err++; $display("FAIL halt_stalled_stays_run: got %b expected 00000", {sf, halted}); end
        load_d = 0;
        #1;
        n_vec++;
        if ({sf, halted} !== 5'b00000) begin n_err++; $display("FAIL halt_accept: got %b expected 00000", {sf, halted}); end
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            lw_hazard();
            rs_e = 2; writereg_m = 2; regwrite_m = 1; pcsrc_d = 1;
            resume = (i == 1);
            #1;
            n_vec++;
            if ({sf, halted, fwd_a_e} !== 7'b1110010) begin
                n_err++; $display("FAIL drain_%0d: got %b expected 1110010", i, {sf, halted, fwd_a_e});
            end
            step();
        end
        resume = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if ({sf, halted, fwd_a_e} !== 7'b1110100) begin
                n_err++; $display("FAIL halted_%0d: got %b expected 1110100", i, {sf, halted, fwd_a_e});
            end
            step();
        end
        n_vec++;
        if (stall_cycles !== 4'd5) begin n_err++; $display("FAIL halt_count: got %0d expected 5", stall_cycles); end
        idle();
        load_d = 0; resume = 1;
        #1;
        n_vec++;
        if ({sf, halted} !== 5'b11101) begin n_err++; $display("FAIL resume_cycle: got %b expected 11101", {sf, halted}); end
        step();
        resume = 0;
        #1;
        n_vec++;
        if ({sf, halted} !== 5'b00010) begin n_err++; $display("FAIL resume_flush: got %b expected 00010", {sf, halted}); end
        step();
        load_d = 1;
        #1;
        n_vec++;
        if ({sf, halted} !== 5'b00000) begin n_err++; $display("FAIL resume_run: got %b expected 00000", {sf, halted}); end
    endtask

    task automatic test_reset_mid_drain();
        idle(); step();
        load_d = 0;
        step();
        load_d = 1;
        step();
        n_vec++;
        if (sf !== 4'b1110) begin n_err++; $display("FAIL pre_reset_drain: got %b expected 1110", sf); end
        #2;
        rst_n = 0;
        #1;
        n_vec++;
        if ({sf, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, halted, stall_cycles} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got sf=%b h=%b cnt=%0d expected all 0", sf, halted, stall_cycles);
        end
        @(negedge clk);
        rst_n = 1;
        step();
        n_vec++;
        if ({sf, halted} !== 5'b00000) begin n_err++; $display("FAIL post_reset_run: got %b expected 00000", {sf, halted}); end
    endtask

    task automatic test_saturation();
        idle();
        lw_hazard();
        for (int i = 0; i < 14; i++) step();
        n_vec++;
        if (stall_cycles !== 4'd14) begin n_err++; $display("FAIL cnt_14: got %0d expected 14", stall_cycles); end
        for (int i = 0; i < 6; i++) step();
        n_vec++;
        if (stall_cycles !== 4'hF) begin n_err++; $display("FAIL cnt_sat: got %0d expected 15", stall_cycles); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_double_forward();
        test_branch_m();
        test_taken_branch();
        test_branch_e_load();
        test_halt();
        test_reset_mid_drain();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
